// File: rtl/decode_ctrl_if.sv
// Decode-stage handshake bundle: IF/ID-side request, flush, and the registered ID/EX control entry.
interface decode_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      alu_opcode;
  logic            pc_select;
  logic            imm_sel_b;
  logic            wb_mem_select;
  logic            regwrite_enable;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            jump;
  logic            jal_select;
  logic [2:0]      imm_select;
  logic [2:0]      funct3_out;
  logic            illegal;
  logic            div_wait;

  modport master (
    output in_valid, instruction, pc_in, flush, out_ready,
    input  in_ready, out_valid, pc_out, alu_opcode, pc_select, imm_sel_b, wb_mem_select,
           regwrite_enable, mem_read, mem_write, branch, jump, jal_select, imm_select,
           funct3_out, illegal, div_wait
  );

  modport slave (
    input  in_valid, instruction, pc_in, flush, out_ready,
    output in_ready, out_valid, pc_out, alu_opcode, pc_select, imm_sel_b, wb_mem_select,
           regwrite_enable, mem_read, mem_write, branch, jump, jal_select, imm_select,
           funct3_out, illegal, div_wait
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32IM decode stage: decodes an instruction into a control bundle and holds it in a single-entry
// ID/EX register with valid/ready handshake, flush, and issue throttling after DIV/REM.
module decode_ctrl_stage #(
  parameter int unsigned XLEN        = 32,
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned DIV_LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  decode_ctrl_if.slave  bus
);

  localparam logic [4:0] AluAdd    = 5'b00000;
  localparam logic [4:0] AluXor    = 5'b00001;
  localparam logic [4:0] AluAnd    = 5'b00010;
  localparam logic [4:0] AluOr     = 5'b00011;
  localparam logic [4:0] AluMul    = 5'b00100;
  localparam logic [4:0] AluMulh   = 5'b00101;
  localparam logic [4:0] AluMulhu  = 5'b00110;
  localparam logic [4:0] AluMulhsu = 5'b00111;
  localparam logic [4:0] AluDiv    = 5'b01000;
  localparam logic [4:0] AluDivu   = 5'b01001;
  localparam logic [4:0] AluRem    = 5'b01010;
  localparam logic [4:0] AluRemu   = 5'b01011;
  localparam logic [4:0] AluSll    = 5'b01101;
  localparam logic [4:0] AluSra    = 5'b01110;
  localparam logic [4:0] AluSlt    = 5'b01111;
  localparam logic [4:0] AluSub    = 5'b10000;
  localparam logic [4:0] AluSltu   = 5'b10001;
  localparam logic [4:0] AluSrl    = 5'b10010;
  localparam logic [4:0] AluPassB  = 5'b10011;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  typedef struct packed {
    logic       pc_sel;
    logic       imm_b;
    logic       wb_mem;
    logic       regwr;
    logic       mrd;
    logic       mwr;
    logic       br;
    logic       jmp;
    logic       jal;
    logic [2:0] imm_sel;
    logic [4:0] alu;
    logic       ill;
  } ctrl_t;

  typedef enum logic {StRun, StDivWait} state_e;

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_alu_r, w_alu_i;
  logic            w_ok_r, w_ok_i, w_ok;
  ctrl_t           w_dec;
  logic            w_in_ready, w_accept, w_hs, w_is_div;
  logic            w_unused_instr;
  state_e          r_state, w_state_nxt;
  logic [4:0]      r_divcnt, w_divcnt_nxt;
  logic            r_valid;
  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_pc;
  logic [2:0]      r_f3;

  assign w_opc          = bus.instruction[6:0];
  assign w_f3           = bus.instruction[14:12];
  assign w_f7           = bus.instruction[31:25];
  assign w_unused_instr = ^{bus.instruction[24:15], bus.instruction[11:7]};

  always_comb begin
    w_alu_r = AluAdd;
    w_ok_r  = 1'b1;
    if (w_f7 == 7'b0000000) begin
      unique case (w_f3)
        3'b000: w_alu_r = AluAdd;
        3'b001: w_alu_r = AluSll;
        3'b010: w_alu_r = AluSlt;
        3'b011: w_alu_r = AluSltu;
        3'b100: w_alu_r = AluXor;
        3'b101: w_alu_r = AluSrl;
        3'b110: w_alu_r = AluOr;
        3'b111: w_alu_r = AluAnd;
      endcase
    end else if (w_f7 == 7'b0100000) begin
      if (w_f3 == 3'b000)      w_alu_r = AluSub;
      else if (w_f3 == 3'b101) w_alu_r = AluSra;
      else                     w_ok_r  = 1'b0;
    end else if (w_f7 == 7'b0000001 && ENABLE_M) begin
      unique case (w_f3)
        3'b000: w_alu_r = AluMul;
        3'b001: w_alu_r = AluMulh;
        3'b010: w_alu_r = AluMulhsu;
        3'b011: w_alu_r = AluMulhu;
        3'b100: w_alu_r = AluDiv;
        3'b101: w_alu_r = AluDivu;
        3'b110: w_alu_r = AluRem;
        3'b111: w_alu_r = AluRemu;
      endcase
    end else begin
      w_ok_r = 1'b0;
    end
  end

  // Only the shift immediates constrain the upper immediate bits.
  always_comb begin
    w_alu_i = AluAdd;
    w_ok_i  = 1'b1;
    unique case (w_f3)
      3'b000: w_alu_i = AluAdd;
      3'b001: begin
        w_alu_i = AluSll;
        w_ok_i  = (w_f7 == 7'b0000000);
      end
      3'b010: w_alu_i = AluSlt;
      3'b011: w_alu_i = AluSltu;
      3'b100: w_alu_i = AluXor;
      3'b101: begin
        if (w_f7 == 7'b0000000)      w_alu_i = AluSrl;
        else if (w_f7 == 7'b0100000) w_alu_i = AluSra;
        else                         w_ok_i  = 1'b0;
      end
      3'b110: w_alu_i = AluOr;
      3'b111: w_alu_i = AluAnd;
    endcase
  end

  always_comb begin
    w_dec = '0;
    w_ok  = 1'b1;
    case (w_opc)
      OpcR: begin
        w_dec.regwr = 1'b1;
        w_dec.alu   = w_alu_r;
        w_ok        = w_ok_r;
      end
      OpcLoad: begin
        w_dec.imm_b  = 1'b1;
        w_dec.wb_mem = 1'b1;
        w_dec.regwr  = 1'b1;
        w_dec.mrd    = 1'b1;
      end
      OpcImm: begin
        w_dec.imm_b = 1'b1;
        w_dec.regwr = 1'b1;
        w_dec.alu   = w_alu_i;
        w_ok        = w_ok_i;
      end
      OpcJalr: begin
        w_dec.imm_b = 1'b1;
        w_dec.regwr = 1'b1;
        w_dec.jmp   = 1'b1;
        w_dec.jal   = 1'b1;
      end
      OpcStore: begin
        w_dec.imm_b   = 1'b1;
        w_dec.mwr     = 1'b1;
        w_dec.imm_sel = 3'b001;
      end
      OpcBranch: begin
        w_dec.pc_sel  = 1'b1;
        w_dec.imm_b   = 1'b1;
        w_dec.br      = 1'b1;
        w_dec.imm_sel = 3'b011;
        w_dec.alu     = AluSub;
      end
      OpcJal: begin
        w_dec.pc_sel  = 1'b1;
        w_dec.imm_b   = 1'b1;
        w_dec.regwr   = 1'b1;
        w_dec.jmp     = 1'b1;
        w_dec.jal     = 1'b1;
        w_dec.imm_sel = 3'b100;
      end
      OpcAuipc: begin
        w_dec.pc_sel  = 1'b1;
        w_dec.imm_b   = 1'b1;
        w_dec.regwr   = 1'b1;
        w_dec.imm_sel = 3'b010;
      end
      OpcLui: begin
        w_dec.imm_b   = 1'b1;
        w_dec.regwr   = 1'b1;
        w_dec.imm_sel = 3'b010;
        w_dec.alu     = AluPassB;
      end
      default: w_ok = 1'b0;
    endcase
    if (!w_ok) begin
      w_dec     = '0;
      w_dec.ill = 1'b1;
    end
  end

  assign w_hs       = r_valid & bus.out_ready;
  assign w_in_ready = !reset & !bus.flush & (r_state == StRun) & (!r_valid | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  // Illegal entries carry ALU=ADD, so a DIV/REM code implies a legal divide.
  assign w_is_div   = (r_ctrl.alu[4:2] == 3'b010);

  always_comb begin
    w_state_nxt  = r_state;
    w_divcnt_nxt = r_divcnt;
    if (bus.flush) begin
      w_state_nxt  = StRun;
      w_divcnt_nxt = '0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_hs && w_is_div && (DIV_LATENCY > 1)) begin
            w_state_nxt  = StDivWait;
            w_divcnt_nxt = 5'(DIV_LATENCY - 1);
          end
        end
        StDivWait: begin
          w_divcnt_nxt = (r_divcnt == '0) ? '0 : r_divcnt - 5'd1;
          if (r_divcnt <= 5'd1) w_state_nxt = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StRun;
      r_divcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_divcnt <= w_divcnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_f3    <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_dec;
      r_pc    <= bus.pc_in;
      r_f3    <= w_dec.ill ? 3'b000 : w_f3;
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.out_valid       = r_valid;
  assign bus.pc_out          = r_pc;
  assign bus.alu_opcode      = r_ctrl.alu;
  assign bus.pc_select       = r_ctrl.pc_sel;
  assign bus.imm_sel_b       = r_ctrl.imm_b;
  assign bus.wb_mem_select   = r_ctrl.wb_mem;
  assign bus.regwrite_enable = r_ctrl.regwr;
  assign bus.mem_read        = r_ctrl.mrd;
  assign bus.mem_write       = r_ctrl.mwr;
  assign bus.branch          = r_ctrl.br;
  assign bus.jump            = r_ctrl.jmp;
  assign bus.jal_select      = r_ctrl.jal;
  assign bus.imm_select      = r_ctrl.imm_sel;
  assign bus.funct3_out      = r_f3;
  assign bus.illegal         = r_ctrl.ill;
  assign bus.div_wait        = (r_state == StDivWait);

endmodule
